// File: rtl/dm_responder.sv
// dm_responder: single-port word-array data memory with sub-word
// loads/stores, alignment/range checks and a four-state access FSM.
module dm_responder #(
    parameter int ADDR_W = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              bad;

    function automatic logic [31:0] extend(input logic [31:0] w,
                                           input logic [2:0]  c,
                                           input logic [1:0]  o);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = o[1] ? w[31:16] : w[15:0];
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        case (c)
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = {16'h0, h};
            3'd3:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h0, b};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] d,
                                          input logic [2:0]  c,
                                          input logic [1:0]  o);
        logic [31:0] r;
        r = w;
        if (c == 3'd1 || c == 3'd2) begin
            if (o[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            case (o)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    assign mem_rdata = mem[idx_q];

    // Reject illegal size codes, misaligned and out-of-range addresses.
    always_comb begin
        bad = 1'b0;
        case (dm_ctrl)
            3'd0:       bad = (addr[1:0] != 2'b00);
            3'd1, 3'd2: bad = addr[0];
            3'd3, 3'd4: bad = 1'b0;
            default:    bad = 1'b1;
        endcase
        if (|addr[31:ADDR_W+2]) bad = 1'b1;
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        idx_d     = idx_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        ctrl_d    = ctrl_q;
        word_d    = word_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    idx_d   = addr[ADDR_W+1:2];
                    off_d   = addr[1:0];
                    wdata_d = wdata;
                    ctrl_d  = dm_ctrl;
                    if (bad) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (we && dm_ctrl == 3'd0) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    word_d  = mem_rdata;
                    state_d = WR;
                end else begin
                    rdata_d = extend(mem_rdata, ctrl_q, off_q);
                    ready_d = 1'b1;
                    state_d = RESP;
                end
            end
            WR: begin
                mem_we    = 1'b1;
                mem_wdata = (ctrl_q == 3'd0) ? wdata_q
                          : merge(word_q, wdata_q, ctrl_q, off_q);
                rdata_d   = 32'h0;
                ready_d   = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers, synchronously cleared.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            wdata_q <= 32'h0;
            ctrl_q  <= 3'd0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array write; reset blocks it, contents are never cleared.
    always_ff @(posedge clk) begin
        if (rstn && mem_we) mem[idx_q] <= mem_wdata;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed table, corner sequences and randomized
// accesses checked against a byte-addressed reference memory.
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_rd = 32'h0;
    logic [7:0]  mb [512];

    dm_responder #(.ADDR_W(7)) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .dm_ctrl(dm_ctrl), .rdata(rdata),
        .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-level reference: size from code, alignment by modulo,
    // loads assembled little-endian and extended arithmetically.
    function automatic void model(input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [2:0] c,
                                  output logic [31:0] rd, output logic e,
                                  output int lat);
        int sz;
        int ai;
        logic [31:0] v;
        sz = (c == 3'd0) ? 4 : (c <= 3'd2) ? 2 : 1;
        e  = (c > 3'd4) || (a % sz != 0) || (a >= 32'd512);
        rd = 32'h0;
        ai = int'(a[8:0]);
        if (e) begin
            lat = 1;
        end else if (w) begin
            for (int i = 0; i < sz; i++) mb[ai+i] = d[8*i +: 8];
            lat = (sz == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[ai+i]) << (8*i));
            if ((c == 3'd1 || c == 3'd3) && v[8*sz-1])
                v = v - (32'd1 << (8*sz));
            rd  = v;
            lat = 2;
        end
    endfunction

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input string name);
        int lat;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; dm_ctrl = c;
        @(posedge clk); #1;
        we = $urandom_range(0, 1);
        addr = $urandom; wdata = $urandom;
        dm_ctrl = 3'($urandom_range(0, 7));
        lat = 1;
        while (!ready && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        req = 1'b0;
        chk({name, " ready"}, 32'(ready), 32'd1);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " err"}, 32'(err), 32'(exp_err));
        chk({name, " rdata"}, rdata, exp_rd);
        last_rd = exp_rd;
        @(posedge clk); #1;
        chk({name, " ready low after"}, 32'(ready), 32'd0);
        chk({name, " err low after"}, 32'(err), 32'd0);
        chk({name, " rdata held"}, rdata, last_rd);
    endtask

    task automatic maccess(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] c,
                           input string name);
        logic [31:0] erd;
        logic        ee;
        int          el;
        model(w, a, d, c, erd, ee, el);
        access(w, a, d, c, erd, ee, el, name);
    endtask

    vec_t vt[22];

    initial begin
        logic [31:0] erd;
        logic        ee;
        int          el;
        int          n;
        logic [31:0] exp3 [3];
        logic [31:0] ra;

        vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'd0, 32'h0,        1'b0, 2};
        vt[1]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hDEADBEEF, 1'b0, 2};
        vt[2]  = '{1'b1, 32'h11,  32'h000000A5, 3'd3, 32'h0,        1'b0, 3};
        vt[3]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hDEADA5EF, 1'b0, 2};
        vt[4]  = '{1'b0, 32'h11,  32'h0,        3'd3, 32'hFFFFFFA5, 1'b0, 2};
        vt[5]  = '{1'b0, 32'h11,  32'h0,        3'd4, 32'h000000A5, 1'b0, 2};
        vt[6]  = '{1'b0, 32'h12,  32'h0,        3'd2, 32'h0000DEAD, 1'b0, 2};
        vt[7]  = '{1'b0, 32'h12,  32'h0,        3'd1, 32'hFFFFDEAD, 1'b0, 2};
        vt[8]  = '{1'b1, 32'h13,  32'h55555555, 3'd0, 32'h0,        1'b1, 1};
        vt[9]  = '{1'b0, 32'h11,  32'h0,        3'd1, 32'h0,        1'b1, 1};
        vt[10] = '{1'b0, 32'h10,  32'h0,        3'd7, 32'h0,        1'b1, 1};
        vt[11] = '{1'b0, 32'h200, 32'h0,        3'd0, 32'h0,        1'b1, 1};
        vt[12] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hDEADA5EF, 1'b0, 2};
        vt[13] = '{1'b1, 32'h12,  32'h1234CAFE, 3'd2, 32'h0,        1'b0, 3};
        vt[14] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hCAFEA5EF, 1'b0, 2};
        vt[15] = '{1'b1, 32'h13,  32'hFFFFFF11, 3'd4, 32'h0,        1'b0, 3};
        vt[16] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h11FEA5EF, 1'b0, 2};
        vt[17] = '{1'b0, 32'h13,  32'h0,        3'd4, 32'h00000011, 1'b0, 2};
        vt[18] = '{1'b0, 32'h10,  32'h0,        3'd1, 32'hFFFFA5EF, 1'b0, 2};
        vt[19] = '{1'b1, 32'h14,  32'h0,        3'd5, 32'h0,        1'b1, 1};
        vt[20] = '{1'b1, 32'h10,  32'hDEADA5EF, 3'd0, 32'h0,        1'b0, 2};
        vt[21] = '{1'b0, 32'h12,  32'h0,        3'd1, 32'hFFFFDEAD, 1'b0, 2};

        rstn = 1'b0; req = 1'b0; we = 1'b0;
        addr = 32'h0; wdata = 32'h0; dm_ctrl = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rdata", rdata, 32'h0);

        for (int i = 0; i < 128; i++)
            maccess(1'b1, 32'(i * 4), $urandom, 3'd0, "fill");

        for (int i = 0; i < 22; i++) begin
            model(vt[i].w, vt[i].a, vt[i].d, vt[i].c, erd, ee, el);
            access(vt[i].w, vt[i].a, vt[i].d, vt[i].c,
                   vt[i].exp_rd, vt[i].exp_err, vt[i].exp_lat,
                   $sformatf("vec%0d", i));
        end

        // Reset asserted during the write cycle must drop the write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20;
        wdata = 32'h12345678; dm_ctrl = 3'd0;
        @(posedge clk); #1;
        req = 1'b0; rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst-in-wr ready", 32'(ready), 32'd0);
        chk("rst-in-wr err", 32'(err), 32'd0);
        chk("rst-in-wr rdata", rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post-rst ready", 32'(ready), 32'd0);
        last_rd = 32'h0;
        maccess(1'b0, 32'h20, 32'h0, 3'd0, "read after aborted wr");

        // Held request yields one strobe per access, three cycles apart.
        for (int k = 0; k < 3; k++) begin
            model(1'b0, 32'(32'h10 + 4 * k), 32'h0, 3'd0, erd, ee, el);
            exp3[k] = erd;
        end
        @(negedge clk);
        req = 1'b1; we = 1'b0; dm_ctrl = 3'd0; addr = 32'h10;
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                if (n < 3) begin
                    chk($sformatf("b2b%0d edge", n), k, 2 + 3 * n);
                    chk($sformatf("b2b%0d rdata", n), rdata, exp3[n]);
                    chk($sformatf("b2b%0d err", n), 32'(err), 32'd0);
                    last_rd = exp3[n];
                end
                n++;
                if (n < 3) addr = 32'(32'h10 + 4 * n);
                else req = 1'b0;
            end
        end
        chk("b2b strobe count", n, 3);
        chk("b2b rdata held", rdata, last_rd);

        for (int i = 0; i < 250; i++) begin
            ra = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 9) == 0)
                ra = ra | (32'd1 << $urandom_range(9, 31));
            maccess(1'($urandom_range(0, 1)), ra, $urandom,
                    3'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning word-address width (2^ADDR_W 32-bit words).
REQ-002 SHALL have port clk  input  1  CPU clock; all state changes on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req  input  1  access request; held high by initiator until ready.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read.
REQ-006 SHALL have port addr  input  32  byte address.
REQ-007 SHALL have port wdata  input  32  store data, right-aligned for sub-word stores.
REQ-008 SHALL have port dm_ctrl  input  3  size code: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
REQ-009 SHALL have port rdata  output  32  registered load result, extended per dm_ctrl.
REQ-010 SHALL have port ready  output  1  one-cycle response strobe.
REQ-011 SHALL have port err  output  1  qualifies ready; access rejected.

Function
REQ-012 SHALL implement FSM states IDLE, RD, WR, RESP; one synchronous single-port word array, little-endian (byte n = bits 8n+7:8n).
REQ-013 SHALL sample req, we, addr, wdata, dm_ctrl only in IDLE; latched values used for the whole access.
REQ-014 SHALL flag an error when: dm_ctrl illegal; word access with addr[1:0]!=0; half access with addr[0]!=0; any of addr[31:ADDR_W+2] nonzero.
REQ-015 Error access: IDLE->RESP, ready=1 err=1 rdata=0, no array write.
REQ-016 Read: IDLE->RD (array read)->RESP; ready=1 and rdata valid 2 cycles after req sampled.
REQ-017 Word write: IDLE->WR (full-word write)->RESP; ready 2 cycles after sampling; rdata=0.
REQ-018 Sub-word write: IDLE->RD->WR->RESP; WR writes read word with selected byte/half lane replaced by wdata[7:0]/wdata[15:0]; other lanes unchanged; ready 3 cycles after sampling.
REQ-019 Load extension: byte/half selected by addr[1:0]; signed codes sign-extend, unsigned codes zero-extend; word returned unchanged.
REQ-020 ready and err SHALL be high exactly one cycle (RESP) per access, low otherwise.
REQ-021 RESP SHALL always return to IDLE; req still high in RESP is not sampled; if still high in IDLE it starts a new access.
REQ-022 rdata SHALL hold its value outside RESP until the next RESP.
REQ-023 Array contents SHALL change only in WR state.

Reset
REQ-024 rstn low at a clock edge: state=IDLE, ready=0, err=0, rdata=0, latched request cleared.
REQ-025 Reset SHALL dominate: rstn low during WR suppresses the array write.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 After rstn high, first access SHALL be sampled on the first edge with req=1.

Verification
REQ-028 Word write 0xDEADBEEF to 0x10, then word read 0x10 -> ready 2 cycles after each sample, rdata=0xDEADBEEF, err=0.
REQ-029 Byte write 0x000000A5 to 0x11 (ctrl 011) -> ready 3 cycles after sample; word read 0x10 -> 0xDEADA5EF.
REQ-030 Byte signed read 0x11 -> 0xFFFFFFA5; byte unsigned read 0x11 -> 0x000000A5; half unsigned read 0x12 -> 0x0000DEAD; half signed read 0x12 -> 0xFFFFDEAD.
REQ-031 Word write to 0x13, half read at 0x11, ctrl 111 at 0x10, word read 0x200 -> each: ready+err next cycle, rdata=0, word 0x10 still 0xDEADA5EF.
REQ-032 Word write 0x12345678 to 0x20 with rstn low in WR cycle -> no ready; read 0x20 returns prior value; all outputs 0 cycle after reset.
REQ-033 req held high for three back-to-back word reads 0x10, 0x14, 0x18 -> ready strobes spaced 3 cycles apart, one per access.
